instruction_fetch: RTL

//  IF stage of the 5-stage MIPS pipeline; sits directly upstream of InstructionDecoder.

---
 rtl/instruction_fetch.sv | 126 ++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// IF stage: holds the PC, reads instruction memory and fills the IF/ID register.
// Optional HALT-word detection is enabled by defining IF_HALT_DETECT_EN.
module instruction_fetch #(
    parameter int PC_BITS          = 32,
    parameter int INSTRUCTION_BITS = 32,
    parameter int IMEM_ADDR_BITS   = 8,
    parameter int IMEM_DEPTH       = 256
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_enable,
    input  logic                        i_PCWrite,
    input  logic                        i_if_id_write,
    input  logic                        i_branch_taken,
    input  logic [PC_BITS-1:0]          i_branch_address,
    input  logic                        i_jump,
    input  logic [PC_BITS-1:0]          i_jump_address,
    input  logic                        i_imem_we,
    input  logic [IMEM_ADDR_BITS-1:0]   i_imem_addr,
    input  logic [INSTRUCTION_BITS-1:0] i_imem_data,
    output logic [INSTRUCTION_BITS-1:0] o_instruction,
    output logic [PC_BITS-1:0]          o_PCNext,
    output logic [PC_BITS-1:0]          o_pc,
    output logic                        o_halt
);

    logic [INSTRUCTION_BITS-1:0] imem_q [IMEM_DEPTH];

    logic [PC_BITS-1:0]          pc_q, pc_d;
    logic [PC_BITS-1:0]          pcnext_q, pcnext_d;
    logic [INSTRUCTION_BITS-1:0] instr_q, instr_d;
    logic [PC_BITS-1:0]          pc_plus4;
    logic [INSTRUCTION_BITS-1:0] fetch_word;

`ifdef IF_HALT_DETECT_EN
    localparam logic [INSTRUCTION_BITS-1:0] HALT_WORD = '1;

    typedef enum logic {RUN, HALTED} state_e;
    state_e state_q, state_d;
`endif

    // Word-addressed read; byte offset and high PC bits are dropped.
    assign fetch_word = imem_q[pc_q[IMEM_ADDR_BITS+1:2]];
    assign pc_plus4   = pc_q + PC_BITS'(4);

    // Load port: writes land regardless of enable or halt state.
    always_ff @(posedge clk) begin
        if (i_imem_we) begin
            imem_q[i_imem_addr] <= i_imem_data;
        end
    end

    // Next PC, IF/ID contents and halt state, in redirect priority order.
    always_comb begin
        pc_d     = pc_q;
        instr_d  = instr_q;
        pcnext_d = pcnext_q;
`ifdef IF_HALT_DETECT_EN
        state_d  = state_q;
`endif
        if (i_enable) begin
`ifdef IF_HALT_DETECT_EN
            if (state_q == HALTED) begin
                instr_d = '0;
            end else
`endif
            if (i_branch_taken) begin
                pc_d     = i_branch_address;
                instr_d  = '0;
                pcnext_d = '0;
            end else if (i_jump) begin
                pc_d     = i_jump_address;
                instr_d  = '0;
                pcnext_d = '0;
            end else begin
                if (i_PCWrite) begin
                    pc_d = pc_plus4;
                end
                if (i_if_id_write) begin
                    instr_d  = fetch_word;
                    pcnext_d = pc_plus4;
                end
`ifdef IF_HALT_DETECT_EN
                // HALT latched into IF/ID: freeze fetch at the HALT address.
                if (i_if_id_write && fetch_word == HALT_WORD) begin
                    state_d = HALTED;
                    pc_d    = pc_q;
                end
`endif
            end
        end
    end

    // PC and IF/ID pipeline registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= '0;
            instr_q  <= '0;
            pcnext_q <= '0;
        end else begin
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pcnext_q <= pcnext_d;
        end
    end

`ifdef IF_HALT_DETECT_EN
    // Fetch FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign o_halt = (state_q == HALTED);
`else
    assign o_halt = 1'b0;
`endif

    assign o_instruction = instr_q;
    assign o_PCNext      = pcnext_q;
    assign o_pc          = pc_q;

endmodule
